dmac_xfer_engine: RTL

DMAC_XFER_ENGINE -- requirements
Module: dmac_xfer_engine

---
 rtl/dmac_xfer_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmac_xfer_engine.sv
// Single-channel DMA beat engine: one AHB read into a word buffer, then one AHB write, repeated count times.
// Outputs decode from the registered state and context; bus errors abort to IDLE with sticky err and irq.
module dmac_xfer_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        Channel_en_1,
    input  logic        Channel_en_2,
    input  logic        con_sel,
    input  logic        Bus_Grant,
    input  logic        cfg_load,
    input  logic [31:0] cfg_src,
    input  logic [31:0] cfg_dst,
    input  logic [15:0] cfg_count,
    input  logic [1:0]  cfg_size,
    input  logic        cfg_src_inc,
    input  logic        cfg_dst_inc,
    input  logic [31:0] HRData,
    input  logic        HReady,
    input  logic        HResp,
    output logic [31:0] HAddr,
    output logic [1:0]  HTrans,
    output logic        HWrite,
    output logic [2:0]  HSize,
    output logic [31:0] HWData,
    output logic        irq,
    output logic        con_new_sel,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] src_addr, dst_addr, buffer;
    logic [15:0] count;
    logic [1:0]  size;
    logic        src_inc, dst_inc;
    logic        zero_pend;
    logic        start;
    logic [31:0] step;

    assign HSize = (size == 2'd3) ? 3'b010 : {1'b0, size};
    assign step  = 32'd1 << HSize;
    assign start = (Channel_en_1 | Channel_en_2) && Bus_Grant && (count != 16'd0)
                   && !irq && !cfg_load;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A zero-length load completes without touching the bus.
                if (!cfg_load && zero_pend) state_nxt = DONE;
                else if (start)             state_nxt = RD_ADDR;
            end
            RD_ADDR: if (HReady) state_nxt = RD_DATA;
            RD_DATA: begin
                if (HResp)       state_nxt = IDLE;
                else if (HReady) state_nxt = WR_ADDR;
            end
            WR_ADDR: if (HReady) state_nxt = WR_DATA;
            WR_DATA: begin
                if (HResp)                    state_nxt = IDLE;
                else if (HReady) begin
                    if (count == 16'd1)       state_nxt = DONE;
                    else if (Bus_Grant)       state_nxt = RD_ADDR;
                    else                      state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        HTrans = 2'b00;
        HWrite = 1'b0;
        HAddr  = 32'd0;
        HWData = 32'd0;
        case (state)
            RD_ADDR: begin
                HTrans = 2'b10;
                HAddr  = src_addr;
            end
            WR_ADDR: begin
                HTrans = 2'b10;
                HWrite = 1'b1;
                HAddr  = dst_addr;
            end
            WR_DATA: HWData = buffer;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src_addr    <= 32'd0;
            dst_addr    <= 32'd0;
            buffer      <= 32'd0;
            count       <= 16'd0;
            size        <= 2'd0;
            src_inc     <= 1'b0;
            dst_inc     <= 1'b0;
            zero_pend   <= 1'b0;
            irq         <= 1'b0;
            err         <= 1'b0;
            con_new_sel <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cfg_load) begin
                    src_addr    <= cfg_src;
                    dst_addr    <= cfg_dst;
                    count       <= cfg_count;
                    size        <= cfg_size;
                    src_inc     <= cfg_src_inc;
                    dst_inc     <= cfg_dst_inc;
                    con_new_sel <= con_sel;
                    zero_pend   <= (cfg_count == 16'd0);
                    irq         <= 1'b0;
                    err         <= 1'b0;
                end
                RD_DATA: begin
                    if (HResp) begin
                        err <= 1'b1;
                        irq <= 1'b1;
                    end else if (HReady) begin
                        buffer <= HRData;
                    end
                end
                WR_DATA: begin
                    if (HResp) begin
                        err <= 1'b1;
                        irq <= 1'b1;
                    end else if (HReady) begin
                        count <= count - 16'd1;
                        if (src_inc) src_addr <= src_addr + step;
                        if (dst_inc) dst_addr <= dst_addr + step;
                    end
                end
                DONE: begin
                    irq       <= 1'b1;
                    zero_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
